vga_sync_gen: RTL

//  Upstream VGA timing stage at the pixel clock. Free-running horizontal and vertical

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_sync_gen_if.sv | 22 ++
 rtl/vga_axis_counter.sv | 79 +++++++
 rtl/vga_sync_gen.sv | 74 +++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and the per-axis phase type,
// used by the sync generator and the colour-pattern generators.
package vga_timing_pkg;

    localparam int unsigned H_VID  = 640;
    localparam int unsigned H_FP   = 16;
    localparam int unsigned H_SYNC = 96;
    localparam int unsigned H_BP   = 48;
    localparam int unsigned H_TOT  = H_VID + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_VID  = 480;
    localparam int unsigned V_FP   = 10;
    localparam int unsigned V_SYNC = 2;
    localparam int unsigned V_BP   = 33;
    localparam int unsigned V_TOT  = V_VID + V_FP + V_SYNC + V_BP;

    typedef enum logic [1:0] {
        PH_VIDEO,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_e;

    function automatic int unsigned axis_total(input int unsigned vid, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return vid + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bundle produced by vga_sync_gen: pixel position plus sync, window and marker flags.
interface vga_sync_gen_if;

    logic [9:0] horizontal_num;
    logic [9:0] vertical_num;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       line_start;
    logic       frame_start;

    modport master (
        output horizontal_num, vertical_num, hsync, vsync,
               video_on, line_start, frame_start
    );

    modport slave (
        input  horizontal_num, vertical_num, hsync, vsync,
               video_on, line_start, frame_start
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter with a VIDEO/FRONT/SYNC/BACK phase FSM.
// Flags are registered from the next count, so they always match the count output.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned VID  = H_VID,
    parameter int unsigned FP   = H_FP,
    parameter int unsigned SYNC = H_SYNC,
    parameter int unsigned BP   = H_BP
) (
    input  logic       clk_25,
    input  logic       rst,
    input  logic       adv,
    output logic [9:0] count,
    output phase_e     phase,
    output logic       wrap,
    output logic       sync_n,
    output logic       active,
    output logic       at_zero
);

    localparam int unsigned TOT = axis_total(VID, FP, SYNC, BP);

    localparam logic [9:0] LAST       = 10'(TOT - 1);
    localparam logic [9:0] FP_START   = 10'(VID);
    localparam logic [9:0] SYNC_START = 10'(VID + FP);
    localparam logic [9:0] BP_START   = 10'(VID + FP + SYNC);

    if (VID < 1 || FP < 1 || SYNC < 1 || BP < 1 || TOT > 1024) begin : g_bad_params
        $error("vga_axis_counter: every timing parameter must be >=1 and the total <=1024");
    end

    logic [9:0] count_next;
    phase_e     phase_next;

    // NOTE: every output of a combinational block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        wrap       = adv && (count == LAST);
        count_next = count;
        phase_next = phase;
        if (adv) begin
            count_next = wrap ? 10'd0 : count + 10'd1;
            if (count_next == FP_START) begin
                phase_next = PH_FRONT;
            end else if (count_next == SYNC_START) begin
                phase_next = PH_SYNC;
            end else if (count_next == BP_START) begin
                phase_next = PH_BACK;
            end else if (count_next == 10'd0) begin
                phase_next = PH_VIDEO;
            end
        end
    end

    // Reset parks the axis on its last blanking position, inside the back porch.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            count   <= LAST;
            phase   <= PH_BACK;
            sync_n  <= 1'b1;
            active  <= 1'b0;
            at_zero <= 1'b0;
        end else begin
            count   <= count_next;
            phase   <= phase_next;
            sync_n  <= (phase_next != PH_SYNC);
            active  <= (phase_next == PH_VIDEO);
            at_zero <= (count_next == 10'd0);
        end
    end

    a_count_in_range : assert property (@(posedge clk_25) disable iff (rst)
        int'(count) < int'(TOT))
        else $error("vga_axis_counter: count reached the axis total");

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: a free-running horizontal axis whose wrap advances the vertical axis.
// Counters and flags come straight from the axis registers, so they share the same cycle.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned HVID  = H_VID,
    parameter int unsigned HFP   = H_FP,
    parameter int unsigned HSYNC = H_SYNC,
    parameter int unsigned HBP   = H_BP,
    parameter int unsigned VVID  = V_VID,
    parameter int unsigned VFP   = V_FP,
    parameter int unsigned VSYNC = V_SYNC,
    parameter int unsigned VBP   = V_BP
) (
    input  logic           clk_25,
    input  logic           rst,
    vga_sync_gen_if.master vga
);

    logic [9:0] h_count, v_count;
    phase_e     h_phase, v_phase;
    logic       h_wrap, v_wrap;
    logic       h_sync_n, v_sync_n;
    logic       h_active, v_active;
    logic       h_at_zero, v_at_zero;

    vga_axis_counter #(
        .VID (HVID),
        .FP  (HFP),
        .SYNC(HSYNC),
        .BP  (HBP)
    ) u_h_axis (
        .clk_25 (clk_25),
        .rst    (rst),
        .adv    (1'b1),
        .count  (h_count),
        .phase  (h_phase),
        .wrap   (h_wrap),
        .sync_n (h_sync_n),
        .active (h_active),
        .at_zero(h_at_zero)
    );

    // Lines advance on the horizontal wrap, so vsync only ever moves at column 0.
    vga_axis_counter #(
        .VID (VVID),
        .FP  (VFP),
        .SYNC(VSYNC),
        .BP  (VBP)
    ) u_v_axis (
        .clk_25 (clk_25),
        .rst    (rst),
        .adv    (h_wrap),
        .count  (v_count),
        .phase  (v_phase),
        .wrap   (v_wrap),
        .sync_n (v_sync_n),
        .active (v_active),
        .at_zero(v_at_zero)
    );

    assign vga.horizontal_num = h_count;
    assign vga.vertical_num   = v_count;
    assign vga.hsync          = h_sync_n;
    assign vga.vsync          = v_sync_n;
    assign vga.video_on       = h_active && v_active;
    assign vga.line_start     = h_at_zero;
    assign vga.frame_start    = h_at_zero && v_at_zero;

    // Phases and the frame wrap are available for debug but not exported.
    logic unused_axis_state;
    assign unused_axis_state = ^{h_phase, v_phase, v_wrap};

endmodule
